// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory stage and the memory system.
// The unit drives the request side; the memory returns the ready, ack and read word.
interface mem_access_unit_if;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [31:0] dmem_addr;
   logic        dmem_we;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
      input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
   );

   modport slave (
      input  dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
      output dmem_req_ready, dmem_rsp_valid, dmem_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: issues one bus transaction per load/store, stalls the pipeline
// until the response arrives, and registers the extended load result.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for MemRead/MemWrite; legal access latched here
// REQ     | dmem_req_valid high, fields held until req_ready
// WAIT    | request accepted, waiting for dmem_rsp_valid
// DONE    | one cycle with Stall low so the pipeline advances
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        Funct3,
   input  logic [31:0]       ALUResult,
   input  logic [31:0]       WriteData,
   mem_access_unit_if.master dmem,
   output logic [31:0]       FinalDataMemoryRead,
   output logic              Stall,
   output logic              MisalignedFault,
   output logic              BusFault
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Counter is one bit wider than needed so it can run one past the limit
   // when a late handshake pushes the transaction into WAIT.
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [1:0]       off_q, off_d;
   logic [2:0]       funct3_q, funct3_d;
   logic             we_q, we_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             mis_q, mis_d;
   logic             bus_q, bus_d;

   logic        access, legal, misaligned;
   logic [3:0]  wstrb_new;
   logic [31:0] wdata_new;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_val;

   // Decode the incoming access: legality, alignment and store lane encoding.
   always_comb begin
      access = MemRead | MemWrite;
      if (MemWrite)
         legal = (Funct3[2] == 1'b0) && (Funct3[1:0] != 2'b11);
      else
         legal = (Funct3[1:0] != 2'b11) && !(Funct3[2] && Funct3[1]);
      misaligned = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                   ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
      wstrb_new = 4'b0000;
      wdata_new = 32'h0;
      if (MemWrite) begin
         case (Funct3[1:0])
            2'b00: begin
               wstrb_new = 4'b0001 << ALUResult[1:0];
               wdata_new = {4{WriteData[7:0]}};
            end
            2'b01: begin
               wstrb_new = 4'b0011 << ALUResult[1:0];
               wdata_new = {2{WriteData[15:0]}};
            end
            default: begin
               wstrb_new = 4'b1111;
               wdata_new = WriteData;
            end
         endcase
      end
   end

   // Pick the addressed lane of the returned word and extend it.
   always_comb begin
      lane_b = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
      lane_h = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
      case (funct3_q)
         3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
         3'b100:  load_val = {24'h0, lane_b};
         3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
         3'b101:  load_val = {16'h0, lane_h};
         default: load_val = dmem.dmem_rdata;
      endcase
   end

   // Transaction sequencing, timeout and result capture.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      off_d    = off_q;
      funct3_d = funct3_q;
      we_d     = we_q;
      wstrb_d  = wstrb_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      mis_d    = 1'b0;
      bus_d    = 1'b0;
      Stall    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access) begin
               if (legal && !misaligned) begin
                  addr_d   = {ALUResult[31:2], 2'b00};
                  off_d    = ALUResult[1:0];
                  funct3_d = Funct3;
                  we_d     = MemWrite;
                  wstrb_d  = wstrb_new;
                  wdata_d  = wdata_new;
                  cnt_d    = '0;
                  Stall    = 1'b1;
                  state_d  = ST_REQ;
               end else begin
                  mis_d = 1'b1;
               end
            end
         end
         ST_REQ: begin
            Stall = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (dmem.dmem_req_ready) begin
               state_d = ST_WAIT;
            end else if (cnt_q >= CNT_LAST) begin
               bus_d   = 1'b1;
               state_d = ST_DONE;
               if (!we_q) rdata_d = 32'h0;
            end
         end
         ST_WAIT: begin
            Stall = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (dmem.dmem_rsp_valid) begin
               state_d = ST_DONE;
               if (!we_q) rdata_d = load_val;
            end else if (cnt_q >= CNT_LAST) begin
               bus_d   = 1'b1;
               state_d = ST_DONE;
               if (!we_q) rdata_d = 32'h0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and request registers; reset drops the request at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= 32'h0;
         off_q    <= 2'b00;
         funct3_q <= 3'b000;
         we_q     <= 1'b0;
         wstrb_q  <= 4'b0000;
         wdata_q  <= 32'h0;
         cnt_q    <= '0;
         rdata_q  <= 32'h0;
         mis_q    <= 1'b0;
         bus_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         off_q    <= off_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         wstrb_q  <= wstrb_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         mis_q    <= mis_d;
         bus_q    <= bus_d;
      end
   end

   assign dmem.dmem_req_valid = (state_q == ST_REQ);
   assign dmem.dmem_addr      = addr_q;
   assign dmem.dmem_we        = we_q;
   assign dmem.dmem_wstrb     = wstrb_q;
   assign dmem.dmem_wdata     = wdata_q;
   assign FinalDataMemoryRead = rdata_q;
   assign MisalignedFault     = mis_q;
   assign BusFault            = bus_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random loads/stores on a long-timeout
// instance, plus timeout and reset-in-flight sequences on a short-timeout instance.
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] ALUResult, WriteData, FinalDataMemoryRead;
   logic        Stall, MisalignedFault, BusFault;
   mem_access_unit_if bus ();

   logic        t_MemRead, t_MemWrite;
   logic [2:0]  t_Funct3;
   logic [31:0] t_ALUResult, t_WriteData, t_Final;
   logic        t_Stall, t_Mis, t_BusFault;
   mem_access_unit_if tbus ();

   mem_access_unit #(.TIMEOUT_CYCLES(32)) dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
      .ALUResult(ALUResult), .WriteData(WriteData), .dmem(bus),
      .FinalDataMemoryRead(FinalDataMemoryRead), .Stall(Stall),
      .MisalignedFault(MisalignedFault), .BusFault(BusFault)
   );

   mem_access_unit #(.TIMEOUT_CYCLES(8)) dut_to (
      .clk(clk), .rst(rst), .MemRead(t_MemRead), .MemWrite(t_MemWrite), .Funct3(t_Funct3),
      .ALUResult(t_ALUResult), .WriteData(t_WriteData), .dmem(tbus),
      .FinalDataMemoryRead(t_Final), .Stall(t_Stall),
      .MisalignedFault(t_Mis), .BusFault(t_BusFault)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] model_final = 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: access width in bytes, legality, and the loaded value.
   function automatic int unsigned size_of(input logic [2:0] f3);
      return 32'd1 << f3[1:0];
   endfunction

   function automatic bit is_legal(input bit st, input logic [2:0] f3);
      if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      int unsigned sz;
      logic [31:0] v, mask;
      sz = size_of(f3);
      if (sz == 4) return rd;
      v    = rd >> (8 * (a % 4));
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v    = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
      int unsigned sz;
      sz = size_of(f3);
      if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
      if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int rdy_dly, input int rsp_dly);
      bit ok;
      int unsigned sz, ws;
      int stall_n;
      sz = size_of(f3);
      ok = is_legal(st, f3) && ((a % sz) == 0);
      ws = st ? (((32'd1 << sz) - 1) << (a % 4)) : 0;
      @(negedge clk);
      MemRead = !st; MemWrite = st; Funct3 = f3; ALUResult = a; WriteData = wd;
      bus.dmem_rsp_valid = 1'($urandom_range(0, 1));
      bus.dmem_rdata = $urandom;
      #1 check("stall_accept", Stall, ok);
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      bus.dmem_rsp_valid = 1'b0;
      if (!ok) begin
         check("mis_pulse", MisalignedFault, 1);
         check("mis_no_req", bus.dmem_req_valid, 0);
         check("mis_stall", Stall, 0);
         @(negedge clk);
         check("mis_one_cycle", MisalignedFault, 0);
         check("mis_final", FinalDataMemoryRead, model_final);
         check("mis_no_req2", bus.dmem_req_valid, 0);
         return;
      end
      stall_n = 1;
      for (int i = 0; i <= rdy_dly; i++) begin
         check("req_valid", bus.dmem_req_valid, 1);
         check("req_addr", bus.dmem_addr, a & 32'hFFFF_FFFC);
         check("req_we", bus.dmem_we, st);
         check("req_wstrb", bus.dmem_wstrb, ws);
         if (st) check("req_wdata", bus.dmem_wdata, store_data(f3, wd));
         stall_n += int'(Stall);
         bus.dmem_req_ready = (i == rdy_dly);
         bus.dmem_rsp_valid = (i == 0) && (rdy_dly > 0);
         bus.dmem_rdata = $urandom;
         @(negedge clk);
      end
      bus.dmem_req_ready = 1'b0;
      for (int i = 0; i <= rsp_dly; i++) begin
         check("wait_valid_low", bus.dmem_req_valid, 0);
         stall_n += int'(Stall);
         bus.dmem_rsp_valid = (i == rsp_dly);
         bus.dmem_rdata = (i == rsp_dly) ? rd : $urandom;
         @(negedge clk);
      end
      bus.dmem_rsp_valid = 1'b0;
      if (!st) model_final = load_val(f3, a, rd);
      check("done_stall", Stall, 0);
      check("final", FinalDataMemoryRead, model_final);
      check("stall_cycles", stall_n, 3 + rdy_dly + rsp_dly);
      check("no_busfault", BusFault, 0);
      @(negedge clk);
      check("idle_stall", Stall, 0);
      check("idle_final", FinalDataMemoryRead, model_final);
   endtask

   task automatic t_load(input logic [31:0] a, input logic [31:0] rd);
      @(negedge clk);
      t_MemRead = 1'b1; t_Funct3 = 3'b010; t_ALUResult = a; tbus.dmem_req_ready = 1'b1;
      @(negedge clk);
      t_MemRead = 1'b0;
      @(negedge clk);
      tbus.dmem_req_ready = 1'b0; tbus.dmem_rsp_valid = 1'b1; tbus.dmem_rdata = rd;
      @(negedge clk);
      tbus.dmem_rsp_valid = 1'b0;
      check("t_load_final", t_Final, rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1;
      MemRead = 0; MemWrite = 0; Funct3 = 0; ALUResult = 0; WriteData = 0;
      t_MemRead = 0; t_MemWrite = 0; t_Funct3 = 0; t_ALUResult = 0; t_WriteData = 0;
      bus.dmem_req_ready = 0; bus.dmem_rsp_valid = 0; bus.dmem_rdata = 0;
      tbus.dmem_req_ready = 0; tbus.dmem_rsp_valid = 0; tbus.dmem_rdata = 0;
      @(negedge clk);
      @(negedge clk);
      check("rst_final", FinalDataMemoryRead, 0);
      check("rst_valid", bus.dmem_req_valid, 0);
      check("rst_addr", bus.dmem_addr, 0);
      check("rst_wstrb", bus.dmem_wstrb, 0);
      check("rst_wdata", bus.dmem_wdata, 0);
      check("rst_we", bus.dmem_we, 0);
      check("rst_stall", Stall, 0);
      check("rst_faults", {MisalignedFault, BusFault}, 0);
      rst = 1'b0;

      do_access(0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0);
      do_access(0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0, 0);
      do_access(0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0, 0);
      do_access(1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'h5555_5555, 0, 0);
      do_access(0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 0, 0);
      do_access(0, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 0, 0);
      do_access(0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 3, 5);

      for (int k = 0; k < 40; k++) begin
         do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom & 32'h0000_FFFF, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end

      t_load(32'h0000_0200, 32'h1234_5678);
      @(negedge clk);
      t_MemRead = 1'b1; t_Funct3 = 3'b010; t_ALUResult = 32'h0000_0300;
      @(negedge clk);
      t_MemRead = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (t_BusFault) break;
         check("to_stall", t_Stall, 1);
         n++;
         @(negedge clk);
      end
      check("to_cycles", n, 8);
      check("to_fault", t_BusFault, 1);
      check("to_final", t_Final, 0);
      check("to_valid", tbus.dmem_req_valid, 0);
      check("to_done_stall", t_Stall, 0);
      @(negedge clk);
      check("to_fault_pulse", t_BusFault, 0);
      check("to_idle_stall", t_Stall, 0);

      t_load(32'h0000_0400, 32'hA5A5_0001);
      @(negedge clk);
      t_MemRead = 1'b1; t_ALUResult = 32'h0000_0500; tbus.dmem_req_ready = 1'b1;
      @(negedge clk);
      t_MemRead = 1'b0;
      check("t_req_valid", tbus.dmem_req_valid, 1);
      @(negedge clk);
      tbus.dmem_req_ready = 1'b0;
      check("t_wait_stall", t_Stall, 1);
      rst = 1'b1;
      #1;
      check("rstw_valid", tbus.dmem_req_valid, 0);
      check("rstw_stall", t_Stall, 0);
      check("rstw_final", t_Final, 0);
      check("rstw_addr", tbus.dmem_addr, 0);
      check("rstw_wstrb", tbus.dmem_wstrb, 0);
      check("rstw_faults", {t_Mis, t_BusFault}, 0);
      @(negedge clk);
      rst = 1'b0;
      tbus.dmem_rsp_valid = 1'b1; tbus.dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      tbus.dmem_rsp_valid = 1'b0;
      check("stray_final", t_Final, 0);
      check("stray_stall", t_Stall, 0);
      check("stray_valid", tbus.dmem_req_valid, 0);
      @(negedge clk);
      check("stray_final2", t_Final, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the core. Takes the EX-stage address (ALUResult), store data and access type. Runs a valid/ready request and response transaction on the data-memory bus.
- Produces FinalDataMemoryRead, which is extracted, sign- or zero-extended and registered, for the write-back result selector.
- Stalls the pipeline while a transaction is outstanding. Flags misaligned, illegal-size and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 256: cycles spent in REQ+WAIT before a bus fault is declared.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- MemRead  in  1  load requested this cycle
- MemWrite  in  1  store requested this cycle; wins if both MemRead and MemWrite are high
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResult  in  32  byte address
- WriteData  in  32  store data, right-aligned
- dmem_req_valid  out  1  bus request valid
- dmem_req_ready  in  1  bus accepts request
- dmem_addr  out  32  word-aligned address {ALUResult[31:2],2'b00}
- dmem_we  out  1  1 = write
- dmem_wstrb  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rsp_valid  in  1  response/ack valid
- dmem_rdata  in  32  read word
- FinalDataMemoryRead  out  32  registered load result
- Stall  out  1  freeze upstream pipeline
- MisalignedFault  out  1  one-cycle pulse
- BusFault  out  1  one-cycle pulse

Behaviour:
- Reset:
  - State = IDLE.
  - FinalDataMemoryRead=0, dmem_req_valid=0, dmem_we=0, dmem_wstrb=0, dmem_addr=0, dmem_wdata=0.
  - Faults=0; timeout counter=0.
  - Reset mid-transaction drops dmem_req_valid immediately. A late dmem_rsp_valid after reset is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On (MemRead|MemWrite) with a legal, aligned access:
    - Latch Funct3, addr[1:0], we, wstrb, wdata into request registers; go to REQ.
    - Stall=1 combinationally in this same cycle.
  - Illegal or misaligned access:
    - Illegal: Funct3 011, 110 or 111; or any store Funct3 other than 000, 001, 010.
    - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
    - Response: MisalignedFault=1 next cycle, for one cycle. No bus request, Stall=0, FinalDataMemoryRead unchanged.
- REQ:
  - dmem_req_valid=1 with the registered fields held stable.
  - On dmem_req_valid & dmem_req_ready -> WAIT; dmem_req_valid falls the next cycle.
- WAIT:
  - On dmem_rsp_valid -> DONE.
  - For loads, on that edge FinalDataMemoryRead <= extracted lane of dmem_rdata selected by addr[1:0]:
    - B: sign-extended byte.
    - BU: zero-extended byte.
    - H/HU: half selected by addr[1], sign- or zero-extended.
    - W: full word.
  - For stores, the response is an ack only; FinalDataMemoryRead is unchanged.
- DONE: one cycle, Stall=0 (pipeline advances on this edge), then -> IDLE. MemRead/MemWrite are not sampled in DONE.
- dmem_rsp_valid in IDLE or REQ is ignored.
- Store encoding:
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{WriteData[7:0]}}.
  - SH: wstrb = 0011 << addr[1:0], wdata = {2{WriteData[15:0]}}.
  - SW: wstrb = 1111.
  - Loads: wstrb = 0000, we = 0.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without completion: dmem_req_valid=0, BusFault pulses for one cycle, FinalDataMemoryRead <= 0 (loads only), go to DONE.
- Latency:
  - Zero-wait bus (ready=1 in REQ, rsp_valid in the next cycle): Stall is high for 3 cycles (IDLE-accept, REQ, WAIT), then DONE.

Test Plan:
1. LB with ALUResult=0x1003, rdata=0x80FF_1234, ready=1, rsp_valid one cycle later -> dmem_addr=0x1000, FinalDataMemoryRead=0xFFFF_FF80, Stall high for exactly 3 cycles.
2. LHU with addr=0x2002, rdata=0xBEEF_0000 -> FinalDataMemoryRead=0x0000_BEEF; same access with LH -> 0xFFFF_BEEF.
3. SB with addr=0x3001, WriteData=0x0000_00AB -> dmem_we=1, wstrb=0010, wdata=0xABAB_ABAB; on ack, FinalDataMemoryRead unchanged.
4. LW with addr=0x4002 -> MisalignedFault pulses for 1 cycle, dmem_req_valid stays 0, Stall stays 0. Funct3=011 load -> same response.
5. LW with ready held low for 3 cycles, then rsp_valid after 5 more -> request fields stable throughout REQ, Stall continuous until DONE, correct data captured.
6. Bus never responds, TIMEOUT_CYCLES=8 -> BusFault after 8 cycles, FinalDataMemoryRead=0, return to IDLE. Assert rst in WAIT of a second access -> all outputs 0 immediately; a later stray rsp_valid is ignored.
